// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, request struct and default operand width.
package alu_pkg;

    localparam int unsigned W = 32;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SLL = 4'b0011;
    localparam alu_op_t ALU_SRL = 4'b0100;
    localparam alu_op_t ALU_SRA = 4'b0101;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_XOR = 4'b1010;

    typedef struct packed {
        alu_op_t        op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [4:0]     shamt;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request/response channel pair into the shared ALU slot.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned W = alu_pkg::W
);
    logic           req_valid;
    logic           req_ready;
    logic [3:0]     req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [4:0]     req_shamt;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_exec.sv
// Purely combinational ALU op evaluation; zero flag reports A == B for every op.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned W = alu_pkg::W
) (
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [4:0]   shamt_i,
    output logic [W-1:0] result_o,
    output logic         zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SLL: result_o = b_i << shamt_i;
            ALU_SRL: result_o = b_i >> shamt_i;
            ALU_SRA: result_o = W'($signed(b_i) >>> shamt_i);
            ALU_SUB: result_o = a_i - b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (a_i == b_i);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters, each with a one-entry response buffer.
// Optional grant counters are built when ALU_STATS_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned W     = alu_pkg::W,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      port0_if,
    alu_arbiter_if.slave      port1_if
`ifdef ALU_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_grants_0,
    output logic [CNT_W-1:0]  stat_grants_1
`endif
);

    logic [1:0]        req_valid, rsp_ready, elig, gnt;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [1:0]        zero_q, zero_d;
    logic [1:0][W-1:0] result_q, result_d;
    logic              ptr_q, ptr_d;

    logic [3:0]        op_sel;
    logic [W-1:0]      a_sel, b_sel;
    logic [4:0]        shamt_sel;
    logic [W-1:0]      alu_result;
    logic              alu_zero;

    assign req_valid = {port1_if.req_valid, port0_if.req_valid};
    assign rsp_ready = {port1_if.rsp_ready, port0_if.rsp_ready};

    // A full buffer may take a new request only in the cycle it drains.
    always_comb begin
        elig = req_valid & (~rsp_valid_q | rsp_ready);
        gnt  = 2'b00;
        if (elig == 2'b11) begin
            gnt[ptr_q] = 1'b1;
        end else begin
            gnt = elig;
        end
    end

    assign port0_if.req_ready = gnt[0];
    assign port1_if.req_ready = gnt[1];

    always_comb begin
        op_sel    = port0_if.req_op;
        a_sel     = port0_if.req_a;
        b_sel     = port0_if.req_b;
        shamt_sel = port0_if.req_shamt;
        if (gnt[1]) begin
            op_sel    = port1_if.req_op;
            a_sel     = port1_if.req_a;
            b_sel     = port1_if.req_b;
            shamt_sel = port1_if.req_shamt;
        end
    end

    alu_exec #(
        .W (W)
    ) u_exec (
        .op_i     (op_sel),
        .a_i      (a_sel),
        .b_i      (b_sel),
        .shamt_i  (shamt_sel),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_comb begin
        rsp_valid_d = gnt | (rsp_valid_q & ~rsp_ready);
        result_d    = result_q;
        zero_d      = zero_q;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i]) begin
                result_d[i] = alu_result;
                zero_d[i]   = alu_zero;
            end
        end
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            result_q    <= '0;
            zero_q      <= '0;
            ptr_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ptr_q       <= ptr_d;
        end
    end

    assign port0_if.rsp_valid  = rsp_valid_q[0];
    assign port0_if.rsp_result = result_q[0];
    assign port0_if.rsp_zero   = zero_q[0];
    assign port1_if.rsp_valid  = rsp_valid_q[1];
    assign port1_if.rsp_result = result_q[1];
    assign port1_if.rsp_zero   = zero_q[1];

`ifdef ALU_STATS_EN
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_grants_0 = cnt_q[0];
    assign stat_grants_1 = cnt_q[1];
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter; also exercises ALU_STATS_EN when defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned CntW = 2;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;

    typedef struct packed {
        logic     v;
        logic     rr;
        alu_req_t r;
    } stim_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
    } dir_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.W(32)) p0 ();
    alu_arbiter_if #(.W(32)) p1 ();

`ifdef ALU_STATS_EN
    logic [CntW-1:0] stat_grants_0, stat_grants_1;
    alu_arbiter #(.W(32), .CNT_W(CntW)) dut (
        .clk           (clk),
        .rst           (rst),
        .port0_if      (p0),
        .port1_if      (p1),
        .stat_grants_0 (stat_grants_0),
        .stat_grants_1 (stat_grants_1)
    );
`else
    alu_arbiter #(.W(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .port0_if (p0),
        .port1_if (p1)
    );
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   pri = 0;
    int   g0  = 0;
    int   g1  = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from plain arithmetic on the op definitions.
    function automatic exp_t ref_alu(input alu_req_t r);
        longint sa, sb, ub, p, x;
        exp_t   e;
        sa = longint'($signed(r.a));
        sb = longint'($signed(r.b));
        ub = longint'({32'd0, r.b});
        p  = longint'(1) << r.shamt;
        case (r.op)
            4'd0:    x = longint'({32'd0, r.a & r.b});
            4'd1:    x = longint'({32'd0, r.a | r.b});
            4'd2:    x = sa + sb;
            4'd3:    x = ub * p;
            4'd4:    x = ub / p;
            4'd5:    x = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
            4'd6:    x = sa - sb;
            4'd10:   x = longint'({32'd0, r.a ^ r.b});
            default: x = 0;
        endcase
        e.res = x[31:0];
        e.z   = (r.a == r.b);
        return e;
    endfunction

    function automatic stim_t rnd_stim(input int vpct, input int rpct);
        stim_t s;
        s.v       = ($urandom_range(0, 99) < vpct);
        s.rr      = ($urandom_range(0, 99) < rpct);
        s.r.op    = 4'($urandom_range(0, 15));
        s.r.a     = $urandom;
        s.r.b     = ($urandom_range(0, 3) == 0) ? s.r.a : $urandom;
        s.r.shamt = 5'($urandom_range(0, 31));
        return s;
    endfunction

    function automatic stim_t mk(input logic v, input logic rr, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
        stim_t s;
        s.v = v; s.rr = rr; s.r.op = op; s.r.a = a; s.r.b = b; s.r.shamt = sh;
        return s;
    endfunction

    task automatic apply(input stim_t s0, input stim_t s1);
        p0.req_valid = s0.v;    p0.rsp_ready = s0.rr;   p0.req_op = s0.r.op;
        p0.req_a     = s0.r.a;  p0.req_b     = s0.r.b;  p0.req_shamt = s0.r.shamt;
        p1.req_valid = s1.v;    p1.rsp_ready = s1.rr;   p1.req_op = s1.r.op;
        p1.req_a     = s1.r.a;  p1.req_b     = s1.r.b;  p1.req_shamt = s1.r.shamt;
    endtask

    // One cycle of stimulus; the expected grant comes from the round-robin rules and the
    // model's own buffer occupancy (monitor has already retired any drained entry).
    task automatic drive(input stim_t s0, input stim_t s1);
        bit e0, e1;
        int w;
        @(posedge clk);
        #1;
        apply(s0, s1);
        @(negedge clk);
        #1;
        e0 = s0.v && (q0.size() == 0);
        e1 = s1.v && (q1.size() == 0);
        w  = -1;
        if (e0 && e1) w = pri;
        else if (e0)  w = 0;
        else if (e1)  w = 1;
        cmp("req_ready_0", p0.req_ready, (w == 0));
        cmp("req_ready_1", p1.req_ready, (w == 1));
        if (w == 0) begin
            q0.push_back(ref_alu(s0.r));
            pri = 1;
            g0++;
        end else if (w == 1) begin
            q1.push_back(ref_alu(s1.r));
            pri = 0;
            g1++;
        end
    endtask

    task automatic do_reset();
        apply('0, '0);
        rst = 1'b1;
        #1;
        cmp("rst_rsp_valid_0", p0.rsp_valid, 0);
        cmp("rst_rsp_valid_1", p1.rsp_valid, 0);
        cmp("rst_rsp_result_0", p0.rsp_result, 0);
        cmp("rst_rsp_result_1", p1.rsp_result, 0);
        cmp("rst_rsp_zero_0", p0.rsp_zero, 0);
        cmp("rst_rsp_zero_1", p1.rsp_zero, 0);
        q0.delete();
        q1.delete();
        pri = 0;
        g0  = 0;
        g1  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare each buffered response against the scoreboard, retire on consume.
    always @(negedge clk) begin
        if (!rst) begin
            cmp("rsp_valid_0", p0.rsp_valid, (q0.size() > 0));
            if (q0.size() > 0) begin
                cmp("rsp_result_0", p0.rsp_result, q0[0].res);
                cmp("rsp_zero_0", p0.rsp_zero, q0[0].z);
                if (p0.rsp_ready) void'(q0.pop_front());
            end
            cmp("rsp_valid_1", p1.rsp_valid, (q1.size() > 0));
            if (q1.size() > 0) begin
                cmp("rsp_result_1", p1.rsp_result, q1[0].res);
                cmp("rsp_zero_1", p1.rsp_zero, q1[0].z);
                if (p1.rsp_ready) void'(q1.pop_front());
            end
`ifdef ALU_STATS_EN
            cmp("stat_grants_0", stat_grants_0, (g0 > 3) ? 3 : g0);
            cmp("stat_grants_1", stat_grants_1, (g1 > 3) ? 3 : g1);
`endif
        end
    end

    dir_t  tbl[5];
    stim_t idle;

    initial begin
        idle = mk(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0);
        tbl[0] = '{op: 4'b0110, a: 32'd5,        b: 32'd5,          sh: 5'd0,  res: 32'd0};
        tbl[1] = '{op: 4'b1010, a: 32'h0000F0F0, b: 32'h00000FF0,   sh: 5'd0,  res: 32'h0000FF00};
        tbl[2] = '{op: 4'b0011, a: 32'd0,        b: 32'd1,          sh: 5'd31, res: 32'h80000000};
        tbl[3] = '{op: 4'b0100, a: 32'd0,        b: 32'h80000000,   sh: 5'd31, res: 32'd1};
        tbl[4] = '{op: 4'b0111, a: 32'h12345678, b: 32'h0F0F0F0F,   sh: 5'd3,  res: 32'd0};

        apply('0, '0);
        #3;
        do_reset();

        // Single requester 0: ADD 7 + -3.
        drive(mk(1'b1, 1'b1, 4'b0010, 32'd7, 32'hFFFFFFFD, 5'd0), idle);
        cmp("add_req_ready_0", p0.req_ready, 1);
        drive(idle, idle);
        cmp("add_result", p0.rsp_result, 32'd4);
        cmp("add_zero", p0.rsp_zero, 0);

        foreach (tbl[i]) begin
            drive(mk(1'b1, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh), idle);
            drive(idle, idle);
            cmp($sformatf("op_%0d_result", i), p0.rsp_result, tbl[i].res);
        end
        cmp("sub_eq_zero_flag", p0.rsp_zero, 0);

        // Contention: both valid every cycle, both draining.
        for (int i = 0; i < 8; i++) begin
            drive(rnd_stim(100, 100), rnd_stim(100, 100));
        end
        drive(idle, idle);

        // Backpressure on requester 1.
        drive(idle, mk(1'b1, 1'b0, 4'b0101, 32'd0, 32'h80000000, 5'd4));
        for (int i = 0; i < 3; i++) begin
            drive(mk(1'b1, 1'b1, 4'b0010, $urandom, $urandom, 5'd0),
                  mk(1'b1, 1'b0, 4'b0010, 32'd1, 32'd1, 5'd0));
            cmp("bp_req_ready_1", p1.req_ready, 0);
            cmp("bp_req_ready_0", p0.req_ready, 1);
            cmp("bp_sra_hold", p1.rsp_result, 32'hF8000000);
        end
        drive(mk(1'b1, 1'b1, 4'b0000, 32'd3, 32'd6, 5'd0),
              mk(1'b1, 1'b1, 4'b0010, 32'd1, 32'd1, 5'd0));
        cmp("bp_release_ready_1", p1.req_ready, 1);
        drive(idle, idle);
        cmp("bp_new_result_1", p1.rsp_result, 32'd2);
        cmp("bp_new_zero_1", p1.rsp_zero, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(rnd_stim(75, 50), rnd_stim(75, 50));
        end

        // Reset while requester 0 holds an unconsumed result.
        drive(mk(1'b1, 1'b0, 4'b0001, 32'h1, 32'h2, 5'd0), idle);
        for (int i = 0; i < 2; i++) begin
            drive(mk(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0), mk(1'b0, 1'b0, 4'd0, 0, 0, 5'd0));
        end
        @(posedge clk);
        #1;
        cmp("pre_rst_valid_0", p0.rsp_valid, 1);
        do_reset();
        drive(rnd_stim(100, 100), rnd_stim(100, 100));
        cmp("post_rst_first_grant_0", p0.req_ready, 1);
        drive(idle, idle);

`ifdef ALU_STATS_EN
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(rnd_stim(100, 100), idle);
        end
        drive(idle, idle);
        cmp("stat_sat_0", stat_grants_0, 3);
        cmp("stat_zero_1", stat_grants_1, 0);
`endif

        repeat (3) drive(idle, idle);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
